// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipe: load-use stall, redirect
// squash, memory-busy freeze and halt drain, with saturating event counters.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  d_rs,
    input  logic [2:0]  d_rt,
    input  logic        d_uses_rs,
    input  logic        d_uses_rt,
    input  logic        x_memread,
    input  logic        x_regwrite,
    input  logic [2:0]  x_writereg,
    input  logic        x_redirect,
    input  logic        x_halt,
    input  logic        m_busy,
    output logic        pc_en,
    output logic        fd_en,
    output logic        fd_nopify,
    output logic        dx_en,
    output logic        dx_nopify,
    output logic        xm_en,
    output logic        mw_en,
    output logic        halted,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t        state;
    logic [DW-1:0] dcnt;
    logic          lu;
    logic          stall_inc;
    logic          flush_inc;

    always_comb begin
        lu = x_memread & x_regwrite &
             ((d_uses_rs & (d_rs == x_writereg)) | (d_uses_rt & (d_rt == x_writereg)));
    end

    always_comb begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        fd_nopify = 1'b0;
        dx_en     = 1'b0;
        dx_nopify = 1'b0;
        xm_en     = 1'b0;
        mw_en     = 1'b0;
        halted    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (rst) begin
            // Reset flushes the front of the pipe with bubbles while letting everything clock.
            pc_en     = 1'b1;
            fd_en     = 1'b1;
            fd_nopify = 1'b1;
            dx_en     = 1'b1;
            dx_nopify = 1'b1;
            xm_en     = 1'b1;
            mw_en     = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (m_busy) begin
                        stall_inc = 1'b1;
                    end else if (x_halt) begin
                        fd_en     = 1'b1;
                        fd_nopify = 1'b1;
                        dx_en     = 1'b1;
                        dx_nopify = 1'b1;
                        xm_en     = 1'b1;
                        mw_en     = 1'b1;
                    end else if (x_redirect) begin
                        pc_en     = 1'b1;
                        fd_en     = 1'b1;
                        fd_nopify = 1'b1;
                        dx_en     = 1'b1;
                        dx_nopify = 1'b1;
                        xm_en     = 1'b1;
                        mw_en     = 1'b1;
                        flush_inc = 1'b1;
                    end else if (lu) begin
                        dx_en     = 1'b1;
                        dx_nopify = 1'b1;
                        xm_en     = 1'b1;
                        mw_en     = 1'b1;
                        stall_inc = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                        fd_en = 1'b1;
                        dx_en = 1'b1;
                        xm_en = 1'b1;
                        mw_en = 1'b1;
                    end
                end
                DRAIN: begin
                    fd_en     = 1'b1;
                    fd_nopify = 1'b1;
                    dx_en     = 1'b1;
                    dx_nopify = 1'b1;
                    xm_en     = ~m_busy;
                    mw_en     = ~m_busy;
                    stall_inc = m_busy;
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            dcnt         <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_inc && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
            if (flush_inc && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
            case (state)
                RUN: begin
                    if (!m_busy && x_halt) begin
                        state <= DRAIN;
                        dcnt  <= DW'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    // Only non-busy cycles move the halt further down the pipe.
                    if (!m_busy) begin
                        dcnt <= dcnt - DW'(1);
                        if (dcnt == DW'(1)) state <= HALTED;
                    end
                end
                HALTED: state <= HALTED;
                default: begin
                    state <= RUN;
                    dcnt  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed and random stimulus, expected outputs queued by a
// behavioural model and compared by an independent monitor on the falling edge.
module tb_hazard_ctrl;
    localparam int DRAIN_CYCLES = 3;

    typedef struct packed {
        logic       rst;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       urs;
        logic       urt;
        logic       memread;
        logic       regwrite;
        logic [2:0] writereg;
        logic       redirect;
        logic       halt;
        logic       busy;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst, d_uses_rs, d_uses_rt, x_memread, x_regwrite, x_redirect, x_halt, m_busy;
    logic [2:0]  d_rs, d_rt, x_writereg;
    logic        pc_en, fd_en, fd_nopify, dx_en, dx_nopify, xm_en, mw_en, halted;
    logic [15:0] stall_cycles, flush_count;

    logic [39:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // Model state: 0 running, 1 draining, 2 halted.
    int          m_mode = 0;
    int          m_left = 0;
    int          m_stall = 0;
    int          m_flush = 0;
    bit          model_valid = 1'b0;

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs),
        .d_uses_rt(d_uses_rt), .x_memread(x_memread), .x_regwrite(x_regwrite),
        .x_writereg(x_writereg), .x_redirect(x_redirect), .x_halt(x_halt), .m_busy(m_busy),
        .pc_en(pc_en), .fd_en(fd_en), .fd_nopify(fd_nopify), .dx_en(dx_en),
        .dx_nopify(dx_nopify), .xm_en(xm_en), .mw_en(mw_en), .halted(halted),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    // Expected control byte order: pc, fd, fd_nop, dx, dx_nop, xm, mw, halted.
    task automatic step(input stim_t s);
        logic [7:0] c;
        bit         hazard;
        @(posedge clk);
        #1;
        rst = s.rst; d_rs = s.rs; d_rt = s.rt; d_uses_rs = s.urs; d_uses_rt = s.urt;
        x_memread = s.memread; x_regwrite = s.regwrite; x_writereg = s.writereg;
        x_redirect = s.redirect; x_halt = s.halt; m_busy = s.busy;
        cyc++;
        if (!model_valid) return;
        hazard = s.memread && s.regwrite &&
                 ((s.urs && s.rs == s.writereg) || (s.urt && s.rt == s.writereg));
        c = 8'b0;
        if (s.rst) c = 8'b1111_1110;
        else if (m_mode == 2) c = 8'b0000_0001;
        else if (m_mode == 1) c = s.busy ? 8'b0111_1000 : 8'b0111_1110;
        else if (s.busy) c = 8'b0;
        else if (s.halt) c = 8'b0111_1110;
        else if (s.redirect) c = 8'b1111_1110;
        else if (hazard) c = 8'b0001_1110;
        else c = 8'b1101_0110;
        exp_q.push_back({c, sat16(m_stall), sat16(m_flush)});
        if (s.rst) begin
            m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
        end else if (m_mode == 1) begin
            if (s.busy) m_stall++;
            else begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end else if (m_mode == 0) begin
            if (s.busy) m_stall++;
            else if (s.halt) begin m_mode = 1; m_left = DRAIN_CYCLES; end
            else if (s.redirect) m_flush++;
            else if (hazard) m_stall++;
        end
    endtask

    always @(negedge clk) begin
        logic [39:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({pc_en, fd_en, fd_nopify, dx_en, dx_nopify, xm_en, mw_en, halted} !== e[39:32]) begin
                errors++;
                $display("FAIL ctrl cyc %0d got %b want %b", cyc,
                         {pc_en, fd_en, fd_nopify, dx_en, dx_nopify, xm_en, mw_en, halted}, e[39:32]);
            end
            checks++;
            if ({stall_cycles, flush_count} !== e[31:0]) begin
                errors++;
                $display("FAIL counters cyc %0d got stall %h flush %h want stall %h flush %h",
                         cyc, stall_cycles, flush_count, e[31:16], e[15:0]);
            end
        end
    end

    stim_t s, z, ld;

    initial begin
        z = '0;
        ld = '0;
        ld.memread = 1; ld.regwrite = 1; ld.writereg = 3; ld.rs = 3; ld.urs = 1; ld.rt = 5;
        rst = 1'b1; d_rs = '0; d_rt = '0; d_uses_rs = 0; d_uses_rt = 0; x_memread = 0;
        x_regwrite = 0; x_writereg = '0; x_redirect = 0; x_halt = 0; m_busy = 0;
        s = z; s.rst = 1;
        step(s);
        model_valid = 1'b1;
        step(s);
        step(z);

        // Load-use bubble, then redirect alone and redirect masking a load-use.
        step(ld);
        step(z);
        s = z; s.redirect = 1; step(s);
        s = ld; s.redirect = 1; step(s);
        step(z);

        // Memory freeze over a load-use, then the single bubble.
        s = ld; s.busy = 1;
        repeat (4) step(s);
        step(ld);
        step(z);

        // Halt drain with a redirect and load-use on the halt cycle.
        s = ld; s.halt = 1; s.redirect = 1; step(s);
        repeat (6) step(ld);
        s = z; s.rst = 1; step(s);

        // Halt drain stretched by two busy cycles.
        s = z; s.halt = 1; step(s);
        step(z);
        s = z; s.busy = 1; step(s); step(s);
        repeat (5) step(z);
        s = z; s.rst = 1; step(s);

        // Reset arriving mid-drain.
        s = z; s.halt = 1; step(s);
        step(z);
        s = z; s.rst = 1; step(s);
        step(z); step(ld); step(z);

        repeat (3000) begin
            s.rst      = ($urandom_range(0, 99) < 1) || (m_mode == 2 && $urandom_range(0, 3) == 0);
            s.rs       = 3'($urandom_range(0, 7));
            s.rt       = 3'($urandom_range(0, 7));
            s.urs      = $urandom_range(0, 1) == 1;
            s.urt      = $urandom_range(0, 1) == 1;
            s.memread  = $urandom_range(0, 9) < 4;
            s.regwrite = $urandom_range(0, 9) < 7;
            s.writereg = 3'($urandom_range(0, 7));
            s.redirect = $urandom_range(0, 99) < 15;
            s.halt     = $urandom_range(0, 99) < 3;
            s.busy     = $urandom_range(0, 99) < 20;
            step(s);
        end

        // Saturation of the stall counter.
        s = z; s.rst = 1; step(s);
        s = z; s.busy = 1;
        repeat (65537) step(s);
        repeat (3) step(s);
        step(ld);
        step(z);

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue left %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. It drives the enable and nopify inputs of the IF/ID (`pipe_fetch`) and ID/EX (`pipe_decode`) stage registers, plus the PC and the later stage-register enables. It detects load-use hazards, squashes younger instructions on execute-stage redirects, freezes the pipe on memory busy, and sequences halt drain.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: cycles from halt leaving ID/EX until the halt has retired from WB.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d_rs`, `d_rt`  in  3 each  source register numbers of the instruction in decode.
- `d_uses_rs`, `d_uses_rt`  in  1 each  decode instruction reads rs / rt.
- `x_memread`, `x_regwrite`  in  1 each  ID/EX outputs (`q_memread`, `q_regwrite`).
- `x_writereg`  in  3  ID/EX `q_writereg`.
- `x_redirect`  in  1  branch taken or any jump resolved in execute this cycle.
- `x_halt`  in  1  ID/EX `q_halt`.
- `m_busy`  in  1  data/instruction memory not ready this cycle.
- `pc_en`  out  1  PC register load enable.
- `fd_en`, `fd_nopify`  out  1 each  IF/ID control.
- `dx_en`, `dx_nopify`  out  1 each  ID/EX control (`en`, `nopify` of `pipe_decode`).
- `xm_en`, `mw_en`  out  1 each  EX/MEM and MEM/WB enables.
- `halted`  out  1  core stopped.
- `stall_cycles`  out  16  count of load-use plus memory-stall cycles, saturating.
- `flush_count`  out  16  count of redirect flushes, saturating.

## Operation
- FSM states: RUN, DRAIN, HALTED. A drain counter `dcnt` is `$clog2(DRAIN_CYCLES+1)` bits wide.
- Load-use hazard `lu` = `x_memread & x_regwrite & ((d_uses_rs & d_rs==x_writereg) | (d_uses_rt & d_rt==x_writereg))`. Register 0 is not special-cased.
- Outputs are combinational from state and inputs. In RUN, priority is highest first:
  - `m_busy`: all enables 0, both nopify 0. Add 1 to `stall_cycles`.
  - `x_halt`: `pc_en`=0, `fd_en`=1, `fd_nopify`=1, `dx_en`=1, `dx_nopify`=1, `xm_en`=`mw_en`=1. Next state DRAIN with `dcnt`=`DRAIN_CYCLES`.
  - `x_redirect`: all enables 1, `fd_nopify`=1, `dx_nopify`=1. Add 1 to `flush_count`.
  - `lu`: `pc_en`=0, `fd_en`=0, `dx_en`=1, `dx_nopify`=1, `xm_en`=`mw_en`=1. Add 1 to `stall_cycles`.
  - Otherwise: all enables 1, both nopify 0.
- DRAIN:
  - `pc_en`=0. `fd_en`=`dx_en`=1 and both nopify 1 (bubbles only).
  - `xm_en`=`mw_en`=`~m_busy`.
  - `dcnt` decrements only when `m_busy`=0; `m_busy` cycles also add 1 to `stall_cycles`.
  - When `dcnt`==1 and `m_busy`=0, next state is HALTED.
  - `x_redirect`, `lu` and `x_halt` are ignored.
- HALTED: all enables 0, nopify 0, `halted`=1. Leave only on `rst`.
- Counters saturate at 16'hFFFF and never wrap. They are not incremented in HALTED.

## Timing
- Hazard response is zero-latency: outputs act in the same cycle the condition is visible. The state change takes effect at the next edge.
- Load-use inserts exactly one bubble. The next cycle the load sits in EX/MEM, so `lu` is 0 and the stalled instruction advances.
- Redirect squashes exactly the two younger instructions (those in F and D). The PC loads the target at the same edge.
- Simultaneous events:
  - `m_busy` wins over all other conditions; a pending `lu`, redirect or halt is re-evaluated the next cycle because the pipe is frozen.
  - `x_halt` with `x_redirect`: halt wins and `flush_count` is unchanged.
  - `x_redirect` with `lu`: redirect wins and `stall_cycles` is unchanged.
- Reset (synchronous, may arrive in any state, including mid-DRAIN):
  - While `rst`=1, all enables are 1, `fd_nopify`=`dx_nopify`=1, `halted`=0.
  - After the edge: state RUN, `dcnt`=0, `stall_cycles`=0, `flush_count`=0.
- `halted` rises exactly `DRAIN_CYCLES` non-busy cycles after the `x_halt` cycle.

## Test plan
- Load-use: `x_memread`=1, `x_regwrite`=1, `x_writereg`=3, `d_rs`=3, `d_uses_rs`=1 -> that cycle `pc_en`=0, `fd_en`=0, `dx_nopify`=1. Next cycle (inputs cleared) all enables 1. `stall_cycles`=1.
- Redirect: `x_redirect` pulse for one cycle -> `fd_nopify`=`dx_nopify`=1, `pc_en`=1. `flush_count` goes 0 to 1. Same cycle with `lu`=1 -> `stall_cycles` stays 0.
- Memory freeze: `m_busy` high 4 cycles during a load-use hazard -> all enables 0 for 4 cycles, then one bubble cycle. `stall_cycles`=5.
- Halt drain: `x_halt` with `DRAIN_CYCLES`=3 -> `pc_en`=0 from that cycle; `halted`=1 on the 4th cycle after. Add 2 `m_busy` cycles during DRAIN -> `halted` is delayed by 2 cycles.
- Reset mid-DRAIN: `rst` at `dcnt`=2 -> next cycle in RUN, `halted`=0, counters 0, normal enables.
- Saturation: preload by running 65537 `m_busy` cycles -> `stall_cycles`=16'hFFFF and it holds there.
